// File: rtl/select_seq_pkg.sv
// Shared types and helpers for the select sequencer that drives the 2-to-4 decoder.
package select_seq_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_SEL = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    // Wrapped step of the select index: dir=0 counts up, dir=1 counts down.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input logic dir);
        logic [SEL_W-1:0] one;
        one = {{(SEL_W-1){1'b0}}, 1'b1};
        return dir ? (sel - one) : (sel + one);
    endfunction

endpackage

// File: rtl/select_sequencer_step_timer.sv
// Dwell counter for the select sequencer: flags the last cycle of each STEP_CYCLES-long hold.
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick_last
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick_last ? '0 : count + 1'b1;
        end
    end

    assign tick_last = (count == LAST);

endmodule

// File: rtl/select_sequencer.sv
// Select/enable generator for the 2-to-4 decoder with single-sweep and continuous modes.
// Optional macro SELECT_SEQ_PINGPONG_EN makes continuous mode bounce between the end values.
module select_sequencer
    import select_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    output logic [SEL_W-1:0] S,
    output logic             enable,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SEL - 1);

    seq_state_e       state;
    logic             mode_q;
    logic             dir_q;
    logic             tick_last;
    logic             in_run;
    logic             at_sweep_end;
    logic [SEL_W-1:0] sel_next;

    assign in_run       = (state == RUN);
    assign sel_next     = next_sel(S, dir_q);
    assign at_sweep_end = mode_q && (S == (dir_q ? '0 : SEL_MAX));

    // The dwell count restarts whenever a run begins or is aborted.
    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_run || stop),
        .run      (in_run),
        .tick_last(tick_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            S      <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        dir_q  <= dir;
                        S      <= dir ? SEL_MAX : '0;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // stop outranks both a step and sweep completion
                    if (stop) begin
                        S      <= '0;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (tick_last) begin
                        if (at_sweep_end) begin
                            S      <= '0;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            S <= sel_next;
`ifdef SELECT_SEQ_PINGPONG_EN
                            if (!mode_q && (sel_next == SEL_MAX || sel_next == '0)) begin
                                dir_q <= ~dir_q;
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    S      <= '0;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_select_sequencer.sv
// Directed bench for select_sequencer: a STEP_CYCLES=4 instance for the main tests and a
// STEP_CYCLES=1 instance for the per-cycle wrap / bounce check.
module tb_select_sequencer;

    logic       clk;
    logic       reset;
    logic       start, stop, mode, dir;
    logic [1:0] sel;
    logic       enable, busy, done;

    logic       start_f, stop_f, mode_f, dir_f;
    logic [1:0] sel_f;
    logic       enable_f, busy_f, done_f;

    int checks = 0;
    int errors = 0;

    select_sequencer #(.STEP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .S(sel), .enable(enable), .busy(busy), .done(done)
    );

    select_sequencer #(.STEP_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .stop(stop_f), .mode(mode_f), .dir(dir_f),
        .S(sel_f), .enable(enable_f), .busy(busy_f), .done(done_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Advance one edge, settle, and check the invariants on the main instance.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        checkOutput("inv_enable_implies_busy", int'(enable & ~busy), 0);
        checkOutput("inv_done_and_busy", int'(done & busy), 0);
        checkOutput("inv_sel_zero_when_idle", int'(!busy && sel != 2'd0), 0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_S"}, int'(sel), 0);
        checkOutput({tag, "_enable"}, int'(enable), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    int exp_fast [8];

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
        start_f = 1'b0; stop_f = 1'b0; mode_f = 1'b0; dir_f = 1'b0;
        applyStimulus();
        checkIdle("reset");
        reset = 1'b0;
        applyStimulus();

        // 1: single sweep up
        mode = 1'b1; dir = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput("sweep_up_S", int'(sel), i / 4);
            checkOutput("sweep_up_enable", int'(enable), 1);
            checkOutput("sweep_up_done", int'(done), 0);
            applyStimulus();
        end
        checkOutput("sweep_up_done_pulse", int'(done), 1);
        checkOutput("sweep_up_enable_off", int'(enable), 0);
        checkOutput("sweep_up_S_zero", int'(sel), 0);
        applyStimulus();
        checkIdle("sweep_up_after");

        // 2: single sweep down
        mode = 1'b1; dir = 1'b1; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput("sweep_dn_S", int'(sel), 3 - i / 4);
            checkOutput("sweep_dn_busy", int'(busy), 1);
            applyStimulus();
        end
        checkOutput("sweep_dn_done_pulse", int'(done), 1);
        checkOutput("sweep_dn_busy_off", int'(busy), 0);
        applyStimulus();
        checkIdle("sweep_dn_after");

        // 3: continuous up wraps, then stop
        mode = 1'b0; dir = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checkOutput("cont_S", int'(sel), (i / 4) % 4);
            checkOutput("cont_enable", int'(enable), 1);
            applyStimulus();
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkIdle("cont_stop");
        applyStimulus();
        checkIdle("cont_stop_next");

        // 4a: start held through a sweep; mode/dir changes must not be picked up
        mode = 1'b1; dir = 1'b0; start = 1'b1;
        applyStimulus();
        mode = 1'b0; dir = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("held_start_S", int'(sel), i / 4);
            applyStimulus();
        end
        checkOutput("held_start_done", int'(done), 1);
        applyStimulus();
        checkOutput("held_start_in_done_ignored", int'(busy), 0);
        applyStimulus();
        checkOutput("held_start_reaccept_busy", int'(busy), 1);
        checkOutput("held_start_reaccept_S", int'(sel), 3);
        start = 1'b0; stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkIdle("held_start_stop");

        // 4b: start and stop together in IDLE -> start wins
        mode = 1'b0; dir = 1'b0; start = 1'b1; stop = 1'b1;
        applyStimulus();
        start = 1'b0; stop = 1'b0;
        checkOutput("start_stop_idle_busy", int'(busy), 1);
        checkOutput("start_stop_idle_enable", int'(enable), 1);
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkIdle("start_stop_idle_exit");

        // 4c: stop on the final step of a sweep suppresses done
        mode = 1'b1; dir = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 15; i++) applyStimulus();
        checkOutput("final_step_S", int'(sel), 3);
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkIdle("final_step_stop");
        applyStimulus();
        checkIdle("final_step_stop_next");

        // 5: reset mid-run with S=2, then restart
        mode = 1'b0; dir = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus();
        checkOutput("midrun_S", int'(sel), 2);
        reset = 1'b1;
        applyStimulus();
        checkIdle("midrun_reset");
        reset = 1'b0;
        applyStimulus();
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("restart_S", int'(sel), i / 4);
            checkOutput("restart_enable", int'(enable), 1);
            applyStimulus();
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkIdle("restart_stop");

        // 6: STEP_CYCLES=1 continuous
`ifdef SELECT_SEQ_PINGPONG_EN
        exp_fast = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
        exp_fast = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        mode_f = 1'b0; dir_f = 1'b0; start_f = 1'b1;
        applyStimulus();
        start_f = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("fast_S", int'(sel_f), exp_fast[i]);
            checkOutput("fast_busy", int'(busy_f), 1);
            applyStimulus();
        end
        stop_f = 1'b1;
        applyStimulus();
        stop_f = 1'b0;
        checkOutput("fast_stop_busy", int'(busy_f), 0);
        checkOutput("fast_stop_S", int'(sel_f), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
